// File: rtl/rng_pkg.sv
// Shared constants and types for the rng_bank generator channels.
package rng_pkg;

    localparam int unsigned LFSR_W = 43;
    localparam int unsigned CASR_W = 37;
    localparam logic [31:0] SEED_MIX = 32'h9E3779B9;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWarm = 2'd1,
        StRun  = 2'd2
    } state_t;

    // Per-channel seed offset so channels loaded from one seed diverge.
    function automatic logic [31:0] seed_offset(input int unsigned k);
        return 32'(k) * SEED_MIX;
    endfunction

endpackage

// File: rtl/rng_core.sv
// One generator channel: 43-bit LFSR combined with a 37-bit rule-90/150 cellular automaton.
module rng_core
    import rng_pkg::*;
#(
    parameter int unsigned OUT_W = 32,
    parameter int unsigned IDX   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      seed,
    output logic [OUT_W-1:0] word
);

    localparam logic [LFSR_W-1:0] LFSR_ONE = {{(LFSR_W-1){1'b0}}, 1'b1};
    localparam logic [CASR_W-1:0] CASR_ONE = {{(CASR_W-1){1'b0}}, 1'b1};

    logic [LFSR_W-1:0] lfsr_q, lfsr_d, lfsr_seed, lfsr_step;
    logic [CASR_W-1:0] casr_q, casr_d, casr_seed, casr_step;

    always_comb begin
        lfsr_seed = {{(LFSR_W-32){1'b0}}, seed ^ seed_offset(IDX)};
        if (lfsr_seed == '0) lfsr_seed = LFSR_ONE;
        casr_seed = {{(CASR_W-32){1'b0}}, seed};
        if (casr_seed == '0) casr_seed = CASR_ONE;

        lfsr_step     = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_W-1]};
        lfsr_step[41] = lfsr_q[40] ^ lfsr_q[42];
        lfsr_step[20] = lfsr_q[19] ^ lfsr_q[42];
        lfsr_step[1]  = lfsr_q[0] ^ lfsr_q[42];

        casr_step = '0;
        for (int i = 1; i < 36; i++) begin
            casr_step[i] = casr_q[i-1] ^ casr_q[i+1];
        end
        // Cell 27 is the single rule-150 cell.
        casr_step[27] = casr_q[26] ^ casr_q[27] ^ casr_q[28];
        casr_step[36] = casr_q[35] ^ casr_q[0];
        casr_step[0]  = casr_q[36] ^ casr_q[1];

        lfsr_d = lfsr_q;
        casr_d = casr_q;
        if (load) begin
            lfsr_d = lfsr_seed;
            casr_d = casr_seed;
        end else if (step) begin
            lfsr_d = lfsr_step;
            casr_d = casr_step;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_ONE;
            casr_q <= CASR_ONE;
        end else begin
            lfsr_q <= lfsr_d;
            casr_q <= casr_d;
        end
    end

    assign word = lfsr_q[OUT_W-1:0] ^ casr_q[OUT_W-1:0];

endmodule

// File: rtl/rng_bank.sv
// Bank of NUM_CH seeded generator channels with warm-up and a valid/ready output register.
module rng_bank
    import rng_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned OUT_W  = 32,
    parameter int unsigned WARMUP = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [31:0]             seed_i,
    input  logic                    ready_i,
    output logic                    valid_o,
    output logic                    busy_o,
    output logic [NUM_CH*OUT_W-1:0] number_o
);

    localparam logic [15:0] WARM_LAST = 16'(WARMUP - 1);

    state_t                    state_q, state_d;
    logic [15:0]               cnt_q, cnt_d;
    logic                      valid_q, valid_d;
    logic [NUM_CH*OUT_W-1:0]   number_q, number_d;
    logic [NUM_CH*OUT_W-1:0]   words;
    logic                      step;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        rng_core #(
            .OUT_W (OUT_W),
            .IDX   (k)
        ) u_core (
            .clk  (clk),
            .rst  (rst),
            .load (load_i),
            .step (step),
            .seed (seed_i),
            .word (words[k*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        valid_d  = valid_q;
        number_d = number_q;
        step     = 1'b0;
        // A load discards any pending word and restarts the warm-up.
        if (load_i) begin
            state_d = (WARMUP == 0) ? StRun : StWarm;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                StWarm: begin
                    step = 1'b1;
                    if (cnt_q == WARM_LAST) begin
                        state_d = StRun;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                StRun: begin
                    if (!valid_q || ready_i) begin
                        step     = 1'b1;
                        valid_d  = 1'b1;
                        number_d = words;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            number_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            valid_q  <= valid_d;
            number_q <= number_d;
        end
    end

    assign valid_o  = valid_q;
    assign busy_o   = (state_q == StWarm);
    assign number_o = number_q;

endmodule

// File: tb/tb_rng_bank.sv
// Randomized self-checking bench for rng_bank against a behavioural model of three instances.
module tb_rng_bank;

    localparam int NCH = 4;
    localparam int OW  = 32;
    localparam int NI  = 3;
    localparam logic [42:0] L_TAPS = (43'd1 << 41) | (43'd1 << 20) | 43'd3;
    localparam logic [36:0] C_MID  = 37'd1 << 27;

    logic              clk = 1'b0;
    logic              rst;
    logic              load;
    logic [31:0]       seed;
    logic              ready [NI];
    logic              valid [NI];
    logic              busy  [NI];
    logic [NCH*OW-1:0] num   [NI];

    always #5 clk = ~clk;

    rng_bank #(.NUM_CH(NCH), .OUT_W(OW), .WARMUP(0)) u_a (
        .clk(clk), .rst(rst), .load_i(load), .seed_i(seed), .ready_i(ready[0]),
        .valid_o(valid[0]), .busy_o(busy[0]), .number_o(num[0])
    );
    rng_bank #(.NUM_CH(NCH), .OUT_W(OW), .WARMUP(0)) u_b (
        .clk(clk), .rst(rst), .load_i(load), .seed_i(seed), .ready_i(ready[1]),
        .valid_o(valid[1]), .busy_o(busy[1]), .number_o(num[1])
    );
    rng_bank #(.NUM_CH(NCH), .OUT_W(OW), .WARMUP(64)) u_w (
        .clk(clk), .rst(rst), .load_i(load), .seed_i(seed), .ready_i(ready[2]),
        .valid_o(valid[2]), .busy_o(busy[2]), .number_o(num[2])
    );

    // Model state: mode 0 = unseeded, 1 = warming, 2 = running.
    int          m_mode  [NI];
    int          m_left  [NI];
    logic        m_valid [NI];
    logic [OW-1:0] m_num [NI][NCH];
    logic [42:0] m_l     [NI][NCH];
    logic [36:0] m_c     [NI][NCH];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;
    bit rand_en = 0;
    logic [NCH*OW-1:0] qa[$];
    logic [NCH*OW-1:0] qb[$];

    function automatic int warm_of(input int m);
        return (m == 2) ? 64 : 0;
    endfunction

    function automatic logic [42:0] l_next(input logic [42:0] l);
        return (l << 1) ^ (l[42] ? L_TAPS : 43'd0);
    endfunction

    function automatic logic [36:0] c_next(input logic [36:0] c);
        logic [36:0] rl, rr;
        rl = {c[35:0], c[36]};
        rr = {c[0], c[36:1]};
        return rl ^ rr ^ (c & C_MID);
    endfunction

    task automatic check(input string name, input int m, input logic [127:0] got,
                         input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h", name, m, got, exp);
        end
    endtask

    task automatic cmp_streams();
        int n;
        n = (qa.size() < qb.size()) ? qa.size() : qb.size();
        for (int i = 0; i < n; i++) check("stream", 1, qb[i], qa[i]);
        qa.delete();
        qb.delete();
    endtask

    // Behavioural model and accepted-word monitor, evaluated on the pre-edge values.
    always @(posedge clk) begin
        if (rst || load) begin
            cmp_streams();
        end else begin
            if (valid[0] && ready[0]) qa.push_back(num[0]);
            if (valid[1] && ready[1]) qb.push_back(num[1]);
        end
        for (int m = 0; m < NI; m++) begin
            if (rst) begin
                m_mode[m] = 0; m_left[m] = 0; m_valid[m] = 1'b0;
                for (int c = 0; c < NCH; c++) begin
                    m_l[m][c] = 43'd1; m_c[m][c] = 37'd1; m_num[m][c] = '0;
                end
            end else if (load) begin
                for (int c = 0; c < NCH; c++) begin
                    logic [31:0] off;
                    off = 32'(64'(c) * 64'h9E3779B9);
                    m_l[m][c] = {11'd0, seed ^ off};
                    m_c[m][c] = {5'd0, seed};
                    if (m_l[m][c] == 0) m_l[m][c] = 43'd1;
                    if (m_c[m][c] == 0) m_c[m][c] = 37'd1;
                end
                m_valid[m] = 1'b0;
                m_left[m]  = warm_of(m);
                m_mode[m]  = (warm_of(m) == 0) ? 2 : 1;
            end else if (m_mode[m] == 1) begin
                for (int c = 0; c < NCH; c++) begin
                    m_l[m][c] = l_next(m_l[m][c]); m_c[m][c] = c_next(m_c[m][c]);
                end
                m_left[m]--;
                if (m_left[m] == 0) m_mode[m] = 2;
            end else if (m_mode[m] == 2 && (!m_valid[m] || ready[m])) begin
                for (int c = 0; c < NCH; c++) begin
                    m_num[m][c] = m_l[m][c][OW-1:0] ^ m_c[m][c][OW-1:0];
                    m_l[m][c] = l_next(m_l[m][c]); m_c[m][c] = c_next(m_c[m][c]);
                end
                m_valid[m] = 1'b1;
            end
        end
        if (rst) chk_en = 1;
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            for (int m = 0; m < NI; m++) begin
                check("valid", m, valid[m], m_valid[m]);
                check("busy", m, busy[m], m_mode[m] == 1);
                for (int c = 0; c < NCH; c++) check("number", m, num[m][c*OW +: OW], m_num[m][c]);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_en) begin
            ready[1] = 1'($urandom_range(0, 1));
            ready[2] = 1'($urandom_range(0, 1));
        end
    end

    task automatic do_load(input logic [31:0] s);
        @(posedge clk); #1; load = 1'b1; seed = s;
        @(posedge clk); #1; load = 1'b0;
    endtask

    initial begin
        logic [OW-1:0] w [8];
        logic [OW-1:0] exp4 [4];
        int nb;
        bit nonconst;
        exp4[0] = 32'h0; exp4[1] = 32'h0; exp4[2] = 32'h0; exp4[3] = 32'h2;
        rst = 1'b1; load = 1'b0; seed = '0;
        ready[0] = 1'b1; ready[1] = 1'b1; ready[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; rand_en = 1;

        // No valid word without a load.
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("idle_valid", 0, valid[0], 1'b0);
        check("idle_busy", 0, busy[0], 1'b0);
        check("idle_number", 0, num[0], '0);

        do_load(32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            check("seq1_word", 0, num[0][OW-1:0], exp4[i]);
        end

        do_load($urandom);
        nb = 0;
        @(negedge clk);
        while (busy[2] && nb < 200) begin
            nb++;
            @(negedge clk);
        end
        check("warm_len", 2, nb, 64);
        check("warm_valid_lo", 2, valid[2], 1'b0);
        @(negedge clk);
        check("first_valid", 2, valid[2], 1'b1);
        repeat (40) @(posedge clk);

        // Reset in the middle of a warm-up.
        do_load($urandom);
        repeat (20) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 2, busy[2], 1'b0);
        repeat (20) @(posedge clk);

        do_load($urandom);
        repeat (150) @(posedge clk);

        do_load(32'd0);
        check("zero_L", 0, m_l[0][0], 43'd1);
        check("zero_C", 0, m_c[0][0], 37'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); @(negedge clk);
            w[i] = num[0][OW-1:0];
        end
        nonconst = 0;
        for (int i = 1; i < 8; i++) if (w[i] != w[0]) nonconst = 1;
        check("zero_w0", 0, w[0], 32'h0);
        check("zero_nonconst", 0, nonconst, 1'b1);

        // Reload while a word is held under backpressure.
        do_load(32'h1234_5678);
        rand_en = 0; ready[1] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("held_valid", 1, valid[1], 1'b1);
        @(posedge clk); #1; load = 1'b1; seed = 32'hCAFE_F00D;
        @(posedge clk); #1; load = 1'b0;
        @(negedge clk);
        check("reload_valid", 1, valid[1], 1'b0);
        rand_en = 1;
        repeat (150) @(posedge clk);
        #1;
        cmp_streams();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
